// File: rtl/bus_master_req.sv
// Single-burst bus requester: m_req/m_grant handshake, then req_len+1 beats; reads return one cycle after the beat.
// Backpressure: req_ready only in IDLE; beats stall while m_grant is low. BUS_TIMEOUT_EN enables the grant-wait timeout.
module bus_master_req #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 16,
    parameter int LEN_W       = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_pop,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              done,
    output logic              err,
    output logic              m_req,
    input  logic              m_grant,
    output logic              m_en,
    output logic              m_wr,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_dout,
    input  logic [DATA_W-1:0] m_din
);

    typedef enum logic [1:0] {IDLE, REQ, XFER, REL} state_t;

    typedef struct packed {
        logic             wr;
        logic [LEN_W-1:0] len;
    } cmd_t;

    state_t            state;
    state_t            state_nxt;
    cmd_t              cmd_q;
    logic [LEN_W-1:0]  beat_cnt;
    logic              rd_pend;
    logic              accept;
    logic              last_beat;
    logic              rel_done;
    logic              tmo_hit;

`ifdef BUS_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_cnt;

    // Counts consecutive no-grant cycles; any grant leaves REQ, so no explicit clear is needed.
    always_ff @(posedge clk) begin
        if (reset || state != REQ) begin
            tmo_cnt <= '0;
        end else if (!m_grant) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign tmo_hit = (state == REQ) && !m_grant && (tmo_cnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else begin
            err <= tmo_hit;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign err     = 1'b0;
`endif

    assign accept    = req_valid && req_ready;
    assign last_beat = m_en && (beat_cnt == cmd_q.len);
    // REL waits for the arbiter to release and for the final read return to land.
    assign rel_done  = (state == REL) && !m_grant && !rd_pend;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req_valid)  state_nxt = REQ;
            REQ: begin
                if (m_grant)      state_nxt = XFER;
                else if (tmo_hit) state_nxt = IDLE;
            end
            XFER: if (last_beat)  state_nxt = REL;
            REL:  if (rel_done)   state_nxt = IDLE;
            default:              state_nxt = IDLE;
        endcase
    end

    // Outputs; gated by reset so the bus is released in the reset cycle itself.
    always_comb begin
        req_ready = (state == IDLE) && !reset;
        m_req     = ((state == REQ) || (state == XFER)) && !reset;
        m_en      = (state == XFER) && m_grant && !reset;
        m_wr      = cmd_q.wr;
        m_dout    = wr_data;
        wr_pop    = m_en && cmd_q.wr;
    end

    // Command, beat address/count and read-return pipeline
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_q    <= '0;
            m_addr   <= '0;
            beat_cnt <= '0;
            rd_pend  <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            done     <= 1'b0;
        end else begin
            rd_pend  <= m_en && !cmd_q.wr;
            rd_valid <= rd_pend;
            if (rd_pend) begin
                rd_data <= m_din;
            end
            done <= rel_done;
            if (accept) begin
                cmd_q    <= '{wr: req_wr, len: req_len};
                m_addr   <= req_addr;
                beat_cnt <= '0;
            end else if (m_en) begin
                m_addr   <= m_addr + 1'b1;
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bus_master_req.sv
module tb_bus_master_req;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_wr;
    logic [15:0] req_addr;
    logic [3:0]  req_len;
    logic [31:0] wr_data;
    logic        wr_pop;
    logic [31:0] rd_data;
    logic        rd_valid, done, err;
    logic        m_req, m_grant, m_en, m_wr;
    logic [15:0] m_addr;
    logic [31:0] m_dout, m_din;

    logic        g1, arb_grant, force_low;
    logic [31:0] wbuf [4];
    logic [1:0]  wr_idx;

    typedef struct packed {
        logic        wr;
        logic [15:0] a;
        logic [31:0] d;
    } beat_t;

    beat_t       exp_beat [$];
    logic [31:0] exp_rd [$];
    int          exp_done;
    int          exp_err;
    int          total;
    int          bad;

    always #5 clk = ~clk;

    bus_master_req #(.DATA_W(32), .ADDR_W(16), .LEN_W(4), .TIMEOUT_CYC(8)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_len(req_len),
        .wr_data(wr_data), .wr_pop(wr_pop),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .done(done), .err(err),
        .m_req(m_req), .m_grant(m_grant), .m_en(m_en), .m_wr(m_wr),
        .m_addr(m_addr), .m_dout(m_dout), .m_din(m_din)
    );

    function automatic logic [31:0] bus_rd(input logic [15:0] a);
        case (a)
            16'h0100: return 32'h0000_1111;
            16'h0101: return 32'h0000_2222;
            default:  return {16'hBEEF, a};
        endcase
    endfunction

    // Arbiter (2-cycle grant latency), bus memory and local write-data source
    assign m_grant = arb_grant & ~force_low;
    assign wr_data = wbuf[wr_idx];
    always @(posedge clk) begin
        g1        <= m_req;
        arb_grant <= g1;
        if (reset || (req_valid && req_ready)) wr_idx <= 2'd0;
        else if (wr_pop)                       wr_idx <= wr_idx + 2'd1;
        if (m_en && !m_wr) m_din <= bus_rd(m_addr);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic monitor();
        beat_t b;
        logic [31:0] d;
        forever begin
            @(negedge clk);
            if (m_en) begin
                chk("beat_expected", exp_beat.size() != 0, 1);
                if (exp_beat.size() != 0) begin
                    b = exp_beat.pop_front();
                    chk("beat_addr", m_addr, b.a);
                    chk("beat_wr", m_wr, b.wr);
                    chk("beat_wr_pop", wr_pop, b.wr);
                    if (b.wr) chk("beat_wdata", m_dout, b.d);
                end
            end
            if (rd_valid) begin
                chk("rdv_expected", exp_rd.size() != 0, 1);
                if (exp_rd.size() != 0) begin
                    d = exp_rd.pop_front();
                    chk("rd_data", rd_data, d);
                end
            end
            if (done) begin
                chk("done_expected", exp_done > 0, 1);
                chk("done_after_reads", exp_rd.size(), 0);
                if (exp_done > 0) exp_done--;
            end
            if (err) begin
                chk("err_expected", exp_err > 0, 1);
                if (exp_err > 0) exp_err--;
            end
        end
    endtask

    task automatic issue(input logic wr, input logic [15:0] a, input logic [3:0] len);
        @(posedge clk); #1;
        req_valid = 1'b1; req_wr = wr; req_addr = a; req_len = len;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic drain(input string nm, input int lim);
        int n = 0;
        while ((exp_beat.size() != 0 || exp_rd.size() != 0 || exp_done != 0 || exp_err != 0) && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk(nm, exp_beat.size() + exp_rd.size() + exp_done + exp_err, 0);
        repeat (6) @(negedge clk);
    endtask

    task automatic wait_en(input string nm);
        int n = 0;
        @(negedge clk);
        while (!m_en && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(nm, m_en, 1);
    endtask

    task automatic push_wr(input logic [15:0] a, input logic [31:0] d0);
        for (int i = 0; i < 4; i++) begin
            wbuf[i] = d0 + 32'(i);
            exp_beat.push_back('{wr: 1'b1, a: a + 16'(i), d: d0 + 32'(i)});
        end
        exp_done++;
    endtask

    initial begin
        int n;
        total = 0; bad = 0; exp_done = 0; exp_err = 0;
        reset = 1'b1; force_low = 1'b0;
        req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_len = '0;
        for (int i = 0; i < 4; i++) wbuf[i] = '0;
        fork monitor(); join_none
        repeat (4) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_m_req", m_req, 0);
        chk("rst_m_en", m_en, 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_flags", {rd_valid, done, err}, 0);

        // Write burst 0x10, len 3: grant latency and release timing
        push_wr(16'h0010, 32'hA0);
        issue(1'b1, 16'h0010, 4'd3);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("wr_m_req_high", m_req, 1);
            chk("wr_first_beat_lat", m_en, (i == 3));
        end
        repeat (3) @(negedge clk);
        @(negedge clk);
        chk("wr_m_req_dropped", m_req, 0);
        chk("wr_no_beat_after_last", m_en, 0);
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("wr_done_seen", done, 1);
        chk("wr_done_grant_low", m_grant, 0);
        drain("wr_drain", 20);

        // Read burst 0x100, len 1: back-to-back returns, done after both
        exp_beat.push_back('{wr: 1'b0, a: 16'h0100, d: 32'h0});
        exp_beat.push_back('{wr: 1'b0, a: 16'h0101, d: 32'h0});
        exp_rd.push_back(32'h0000_1111);
        exp_rd.push_back(32'h0000_2222);
        exp_done++;
        issue(1'b0, 16'h0100, 4'd1);
        n = 0;
        @(negedge clk);
        while (!rd_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rd_first_valid", rd_valid, 1);
        @(negedge clk);
        chk("rd_second_valid_b2b", rd_valid, 1);
        drain("rd_drain", 20);

        // Address wrap
        push_wr(16'hFFFE, 32'hB0);
        issue(1'b1, 16'hFFFE, 4'd3);
        drain("wrap_drain", 40);

        // Grant loss for 3 cycles after the first beat
        push_wr(16'h0200, 32'hC0);
        issue(1'b1, 16'h0200, 4'd3);
        wait_en("gl_first_beat");
        @(posedge clk); #1 force_low = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("gl_m_en_paused", m_en, 0);
            chk("gl_m_req_held", m_req, 1);
        end
        @(posedge clk); #1 force_low = 1'b0;
        drain("gl_drain", 40);

        // Reset after one read beat: bus released, no done, no read return
        exp_beat.push_back('{wr: 1'b0, a: 16'h0300, d: 32'h0});
        issue(1'b0, 16'h0300, 4'd3);
        wait_en("rst_mid_first_beat");
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_m_en_gated", m_en, 0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_m_req", m_req, 0);
        chk("rst_mid_m_en", m_en, 0);
        chk("rst_mid_req_ready", req_ready, 1);
        drain("rst_mid_drain", 10);

`ifdef BUS_TIMEOUT_EN
        // Grant withheld: err 8 cycles after entering REQ, command dropped
        force_low = 1'b1;
        exp_err++;
        issue(1'b0, 16'h0400, 4'd0);
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            if (i == 7) chk("tmo_req_before", m_req, 1);
            if (i < 8)  chk("tmo_err_early", err, 0);
        end
        chk("tmo_err_pulse", err, 1);
        chk("tmo_m_req_low", m_req, 0);
        chk("tmo_idle", req_ready, 1);
        @(posedge clk); #1 force_low = 1'b0;
        drain("tmo_drain", 10);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
